// File: rtl/router_pkg.sv
// Shared definitions for the XY mesh router: port indices, widths and the
// output-arbiter state type.
package router_pkg;

    localparam int unsigned N_PORTS    = 5;
    localparam int unsigned FLIT_WIDTH = 40;
    localparam int unsigned PTR_WIDTH  = $clog2(N_PORTS);

    // Input channel index order, also the round-robin scan order.
    typedef enum logic [2:0] {
        PortHome  = 3'd0,
        PortNorth = 3'd1,
        PortEast  = 3'd2,
        PortSouth = 3'd3,
        PortWest  = 3'd4
    } port_idx_t;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: returns the one-hot first set request
// found when scanning upward from ptr with wrap-around.
module rr_picker #(
    parameter int unsigned NUM_REQ   = 5,
    parameter int unsigned PTR_WIDTH = 3
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [PTR_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]   winner
);

    logic                 found;
    logic [PTR_WIDTH-1:0] idx;

    // Circular scan starting at ptr; the first hit wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = PTR_WIDTH'((32'(ptr) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xy_output_arbiter.sv
// Packet-granular round-robin arbiter and AXIS output mux for one router
// output link. Locks onto one input until its TLAST beat transfers.
module xy_output_arbiter
    import router_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = N_PORTS,
    parameter int unsigned DATA_WIDTH = FLIT_WIDTH
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NUM_PORTS-1:0]                 req_valid_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_PORTS-1:0]                 req_last_i,
    output logic [NUM_PORTS-1:0]                 req_ready_o,
    output logic                                 out_valid_o,
    output logic [DATA_WIDTH-1:0]                out_data_o,
    output logic                                 out_last_o,
    input  logic                                 out_ready_i,
    output logic [NUM_PORTS-1:0]                 grant_o,
    output logic                                 busy_o
);

    localparam int unsigned PtrW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    arb_state_t             state_q, state_d;
    logic [NUM_PORTS-1:0]   grant_q, grant_d;
    logic [NUM_PORTS-1:0]   pick;
    logic [PtrW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [PtrW-1:0]        grant_idx;
    logic                   mux_valid;
    logic                   mux_last;
    logic [DATA_WIDTH-1:0]  mux_data;
    logic                   pkt_end;

    rr_picker #(
        .NUM_REQ  (NUM_PORTS),
        .PTR_WIDTH(PtrW)
    ) u_rr_picker (
        .req   (req_valid_i),
        .ptr   (rr_ptr_q),
        .winner(pick)
    );

    // AND-OR mux; grant_q is all zero outside LOCKED so everything idles low.
    always_comb begin
        mux_valid   = 1'b0;
        mux_last    = 1'b0;
        mux_data    = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            mux_valid = mux_valid | (grant_q[i] & req_valid_i[i]);
            mux_last  = mux_last  | (grant_q[i] & req_last_i[i]);
            mux_data  = mux_data  | ({DATA_WIDTH{grant_q[i]}} & req_data_i[i]);
        end
        req_ready_o = grant_q & {NUM_PORTS{out_ready_i}};
    end

    assign out_valid_o = mux_valid;
    assign out_last_o  = mux_last;
    assign out_data_o  = mux_data;
    assign grant_o     = grant_q;
    assign pkt_end     = (state_q == LOCKED) & mux_valid & out_ready_i & mux_last;

    // Binary index of the locked input, used to rotate priority past it.
    always_comb begin
        grant_idx = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (grant_q[i]) begin
                grant_idx = PtrW'(i);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: lock on any request, release on the TLAST handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req_valid_i) state_d = LOCKED;
            LOCKED:  if (pkt_end)      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy_o = (state_q == LOCKED);
    end

    // Grant and priority pointer next values.
    always_comb begin
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        if (state_q == IDLE) begin
            grant_d = pick;
        end else if (pkt_end) begin
            grant_d  = '0;
            rr_ptr_d = (grant_idx == PtrW'(NUM_PORTS - 1)) ? '0 : grant_idx + PtrW'(1);
        end
    end

    // Grant and pointer registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_xy_output_arbiter.sv
// Self-checking bench for xy_output_arbiter: per-port AXIS packet drivers,
// a packet-level round-robin reference model checked every cycle, and
// directed scenarios pinned with hand-computed expectations.
module tb_xy_output_arbiter;

    localparam int NP = 5;
    localparam int DW = 40;
    localparam int TR = 4096;

    logic                   clk;
    logic                   rst;
    logic [NP-1:0]          req_valid;
    logic [NP-1:0][DW-1:0]  req_data;
    logic [NP-1:0]          req_last;
    logic [NP-1:0]          req_ready;
    logic                   out_valid;
    logic [DW-1:0]          out_data;
    logic                   out_last;
    logic                   out_ready;
    logic [NP-1:0]          grant;
    logic                   busy;

    xy_output_arbiter dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_valid_i(req_valid),
        .req_data_i (req_data),
        .req_last_i (req_last),
        .req_ready_o(req_ready),
        .out_valid_o(out_valid),
        .out_data_o (out_data),
        .out_last_o (out_last),
        .out_ready_i(out_ready),
        .grant_o    (grant),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int t0;

    // Reference model: packet owner and next-priority index.
    bit m_locked = 0;
    int m_g      = 0;
    int m_ptr    = 0;

    // Driver state per input.
    int          pend[NP], len[NP], beat[NP], pktn[NP], hold[NP];
    int          gap_at[NP], gap_len[NP], gap_left[NP];
    logic [DW-1:0] base[NP];
    int          fixed_len;
    int unsigned gap_pct, ready_pct;
    bit          ready_q[$];
    logic [NP-1:0] hs;
    int          drv_beats, out_beats;

    // Cycle traces and grant log for the directed checks.
    logic [NP-1:0] tr_grant[TR];
    logic [NP-1:0] tr_ready[TR];
    logic          tr_valid[TR], tr_last[TR], tr_oready[TR];
    logic [DW-1:0] tr_data[TR];
    int            glog[$], glog_t[$];
    logic [NP-1:0] prev_grant = '0;

    logic [NP-1:0] eg, er;
    logic          eb, ev, el;
    logic [DW-1:0] ed;

    function automatic int model_pick(input logic [NP-1:0] v, input int ptr);
        for (int i = 0; i < NP; i++) begin
            if (v[(ptr + i) % NP]) return (ptr + i) % NP;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Per-cycle comparison against the model, then model advance.
    always @(negedge clk) begin
        int w;
        eg = '0; er = '0; eb = 1'b0; ev = 1'b0; el = 1'b0; ed = '0;
        if (!rst && m_locked) begin
            eg = NP'(1) << m_g;
            eb = 1'b1;
            ev = req_valid[m_g];
            el = req_last[m_g];
            ed = req_data[m_g];
            er = out_ready ? eg : '0;
        end
        n_checks++;
        if ({grant, busy, out_valid, out_last, out_data, req_ready} ===
            {eg, eb, ev, el, ed, er}) begin
            n_pass++;
        end else begin
            $display("FAIL cycle %0d: got g=%b b=%b v=%b l=%b d=%h r=%b expected g=%b b=%b v=%b l=%b d=%h r=%b",
                     cyc, grant, busy, out_valid, out_last, out_data, req_ready,
                     eg, eb, ev, el, ed, er);
        end
        if (rst) begin
            m_locked = 0;
            m_ptr    = 0;
        end else if (!m_locked) begin
            w = model_pick(req_valid, m_ptr);
            if (w >= 0) begin
                m_locked = 1;
                m_g      = w;
            end
        end else if (req_valid[m_g] && out_ready && req_last[m_g]) begin
            m_locked = 0;
            m_ptr    = (m_g + 1) % NP;
        end
        hs = req_valid & req_ready;
        if (!rst && out_valid && out_ready) out_beats++;
        if (grant != '0 && prev_grant == '0) begin
            for (int i = 0; i < NP; i++) if (grant[i]) glog.push_back(i);
            glog_t.push_back(cyc);
        end
        prev_grant = grant;
        if (cyc < TR) begin
            tr_grant[cyc]  = grant;
            tr_ready[cyc]  = req_ready;
            tr_valid[cyc]  = out_valid;
            tr_last[cyc]   = out_last;
            tr_oready[cyc] = out_ready;
            tr_data[cyc]   = out_data;
        end
        cyc++;
    end

    task automatic clear_drv();
        for (int p = 0; p < NP; p++) begin
            pend[p] = 0; len[p] = 1; beat[p] = 0; pktn[p] = 0; hold[p] = 0;
            gap_at[p] = -1; gap_len[p] = 0; gap_left[p] = 0;
            base[p] = {8'(p + 1), 32'h0};
        end
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        ready_q.delete();
        fixed_len = 0;
        gap_pct   = 0;
        ready_pct = 100;
    endtask

    // AXIS-legal source: an offered beat stays until accepted.
    task automatic drive_cycle();
        for (int p = 0; p < NP; p++) begin
            if (hs[p]) begin
                drv_beats++;
                beat[p]++;
                if (beat[p] == len[p]) begin
                    beat[p] = 0;
                    pktn[p]++;
                    pend[p]--;
                    len[p] = (fixed_len > 0) ? fixed_len : int'($urandom_range(1, 4));
                end else if (beat[p] == gap_at[p]) begin
                    gap_left[p] = gap_len[p];
                end
            end
            if (!(req_valid[p] && !hs[p])) begin
                if (hold[p] > 0) begin
                    hold[p]--;
                    req_valid[p] = 1'b0;
                end else if (gap_left[p] > 0) begin
                    gap_left[p]--;
                    req_valid[p] = 1'b0;
                end else if (pend[p] > 0 && $urandom_range(0, 99) >= gap_pct) begin
                    req_valid[p] = 1'b1;
                    req_data[p]  = base[p] + DW'(pktn[p] * 16 + beat[p]);
                    req_last[p]  = (beat[p] == len[p] - 1);
                end else begin
                    req_valid[p] = 1'b0;
                end
            end
        end
        if (ready_q.size() > 0) out_ready = ready_q.pop_front();
        else out_ready = ($urandom_range(0, 99) < ready_pct);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) t0 = cyc;
            drive_cycle();
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        clear_drv();
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        glog.delete();
        glog_t.delete();
    endtask

    function automatic int count_grant(input int a, input int b, input logic [NP-1:0] g);
        int c = 0;
        for (int t = a; t <= b; t++) if (tr_grant[t] == g) c++;
        return c;
    endfunction

    initial begin
        int t1, cnt, sum;
        bit done;
        rst = 1'b1;
        out_ready = 1'b0;
        hs = '0;
        drv_beats = 0;
        out_beats = 0;
        clear_drv();
        #2;
        chk("reset_outputs", {grant, busy, out_valid, out_last, out_data, req_ready}, '0);

        // Single requester, 3-beat HOME packet A1..A3.
        do_reset();
        base[0] = 40'hA1; fixed_len = 3; pend[0] = 1; len[0] = 3;
        run(5);
        chk("single_idle_first", {tr_grant[t0], tr_valid[t0]}, '0);
        chk("single_beat1", {tr_grant[t0+1], tr_valid[t0+1], tr_last[t0+1], tr_data[t0+1]},
            {5'b00001, 1'b1, 1'b0, 40'hA1});
        chk("single_beat2", {tr_grant[t0+2], tr_valid[t0+2], tr_last[t0+2], tr_data[t0+2]},
            {5'b00001, 1'b1, 1'b0, 40'hA2});
        chk("single_beat3", {tr_grant[t0+3], tr_valid[t0+3], tr_last[t0+3], tr_data[t0+3]},
            {5'b00001, 1'b1, 1'b1, 40'hA3});
        chk("single_release", {tr_grant[t0+4], tr_valid[t0+4]}, '0);
        // Pointer now 1: EAST beats HOME.
        fixed_len = 1; pend[0] = 1; len[0] = 1; pend[2] = 1; len[2] = 1;
        run(4);
        chk("single_ptr_rotated", tr_grant[t0+1], 5'b00100);

        // Fairness: five ports, two 2-beat packets each.
        do_reset();
        fixed_len = 2;
        for (int p = 0; p < NP; p++) begin pend[p] = 2; len[p] = 2; end
        run(34);
        chk("fair_grants", glog.size(), 10);
        for (int i = 0; i < 10 && i < glog.size(); i++) chk("fair_order", glog[i], i % NP);
        if (glog_t.size() == 10) chk("fair_spacing", glog_t[9] - glog_t[0], 27);
        cnt = 0;
        if (glog_t.size() > 0)
            for (int t = glog_t[0]; t < glog_t[0] + 15; t++)
                if (tr_grant[t] == 5'b00001 && tr_valid[t] && tr_oready[t]) cnt++;
        chk("fair_home_share", cnt, 2);

        // Backpressure and valid gap on a locked NORTH packet.
        do_reset();
        fixed_len = 4;
        pend[1] = 1; len[1] = 4; gap_at[1] = 1; gap_len[1] = 2;
        pend[0] = 1; len[0] = 4; hold[0] = 2;
        pend[2] = 1; len[2] = 4; hold[2] = 2;
        ready_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        run(22);
        chk("bp_lock_len", count_grant(t0, t0 + 8, 5'b00010), 7);
        chk("bp_gap", {tr_valid[t0+2], tr_valid[t0+3], tr_valid[t0+4]}, 3'b001);
        cnt = 0;
        sum = 0;
        for (int t = t0; t <= t0 + 8; t++) begin
            if (tr_grant[t] == 5'b00010 && tr_valid[t] && tr_oready[t]) cnt++;
            if ((tr_ready[t] & ~5'b00010) != '0) sum++;
        end
        chk("bp_beats", cnt, 4);
        chk("bp_no_other_ready", sum, 0);
        chk("bp_next_east", tr_grant[t0+9], 5'b00100);

        // Single-beat SOUTH packet while HOME arrives at its end.
        do_reset();
        fixed_len = 1;
        pend[3] = 1; len[3] = 1;
        pend[0] = 1; len[0] = 1; hold[0] = 1;
        run(6);
        chk("sb_south", {tr_grant[t0+1], tr_last[t0+1], tr_oready[t0+1]}, {5'b01000, 1'b1, 1'b1});
        chk("sb_bubble", tr_grant[t0+2], 5'b00000);
        chk("sb_home", tr_grant[t0+3], 5'b00001);

        // Wrap-around: pointer at WEST after SOUTH, then EAST.
        do_reset();
        fixed_len = 1;
        pend[3] = 1; len[3] = 1;
        pend[2] = 1; len[2] = 1; hold[2] = 1;
        pend[4] = 1; len[4] = 1; hold[4] = 1;
        run(8);
        chk("wrap_west", tr_grant[t0+3], 5'b10000);
        chk("wrap_east", tr_grant[t0+5], 5'b00100);

        // Asynchronous reset during beat 2 of a 4-beat EAST packet.
        do_reset();
        fixed_len = 4; base[2] = 40'hE0;
        pend[2] = 1; len[2] = 4;
        run(3);
        #2;
        chk("rst_pre", {grant, out_valid, out_data}, {5'b00100, 1'b1, 40'hE1});
        rst = 1'b1;
        #1;
        chk("rst_async", {grant, busy, out_valid, out_last, out_data, req_ready}, '0);
        clear_drv();
        @(posedge clk);
        #1;
        rst = 1'b0;
        fixed_len = 1;
        pend[0] = 1; pend[2] = 1; pend[4] = 1;
        run(4);
        chk("rst_home_first", tr_grant[t0+1], 5'b00001);

        // Randomized traffic checked by the per-cycle model.
        do_reset();
        drv_beats = 0;
        out_beats = 0;
        gap_pct = 25;
        ready_pct = 70;
        for (int p = 0; p < NP; p++) begin
            pend[p] = int'($urandom_range(3, 6));
            len[p]  = int'($urandom_range(1, 4));
            hold[p] = int'($urandom_range(0, 8));
        end
        done = 0;
        for (int i = 0; i < 4000 && !done; i++) begin
            run(1);
            sum = 0;
            for (int p = 0; p < NP; p++) sum += pend[p];
            done = (sum == 0) && (req_valid == '0);
        end
        chk("random_drained", done, 1);
        chk("random_beat_count", out_beats, drv_beats);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/xy_output_arbiter.md
# xy_output_arbiter

Packet-granular round-robin arbiter and output multiplexer for one output port of the XY mesh router. It sits between the five router input channels (HOME, NORTH, EAST, SOUTH, WEST) and one outgoing link. It selects one requester and locks onto it until the beat carrying TLAST completes, then rotates priority. The router instantiates five of these, one per output direction, to share each output link among the inputs routed to it.

## Interface
- NUM_PORTS, 5, number of requesting input channels, index order HOME=0, NORTH=1, EAST=2, SOUTH=3, WEST=4.
- DATA_WIDTH, 40, width of the flattened flit payload carried through.
- clk_i  input  1  single clock; all state updates on rising edge.
- rst_i  input  1  reset, asynchronous and active-high; one clock.
- req_valid_i  input  NUM_PORTS  per-input TVALID of flits destined for this output.
- req_data_i  input  NUM_PORTS x DATA_WIDTH  per-input flit payload.
- req_last_i  input  NUM_PORTS  per-input TLAST.
- req_ready_o  output  NUM_PORTS  per-input TREADY; only the locked input can see 1.
- out_valid_o  output  1  TVALID toward the link.
- out_data_o  output  DATA_WIDTH  payload of the locked input.
- out_last_o  output  1  TLAST of the locked input.
- out_ready_i  input  1  TREADY from the link.
- grant_o  output  NUM_PORTS  one-hot registered grant; all zero when idle.
- busy_o  output  1  high while in LOCKED.

## Operation
- States: IDLE, LOCKED. Registers: grant_q (one-hot), rr_ptr_q (log2 NUM_PORTS bits, highest-priority index).
- IDLE: if any req_valid_i is set, pick the first set bit scanning circularly from rr_ptr_q upward with wrap-around. Load grant_q with it and go to LOCKED. If no request is set, stay in IDLE. All outputs are inactive in IDLE.
- LOCKED:
  - out_valid_o = req_valid_i[g]; out_data_o = req_data_i[g]; out_last_o = req_last_i[g].
  - req_ready_o[g] = out_ready_i; all other req_ready_o bits are 0.
- Packet end is a beat with out_valid_o & out_ready_i & out_last_o. On packet end:
  - go to IDLE;
  - clear grant_q;
  - set rr_ptr_q = (g+1) mod NUM_PORTS, wrapping from NUM_PORTS-1 to 0.
- The lock holds regardless of valid gaps. If the locked input drops req_valid_i mid-packet, stay in LOCKED with out_valid_o=0. Other requesters are never granted mid-packet.
- A single-beat packet (TLAST on the first beat) is legal: LOCKED lasts one cycle if out_ready_i=1.
- A requester that is not granted keeps its valid and data stable (AXIS rule); the arbiter does not buffer.
- A requester that asserts valid in the same cycle as a packet end is considered in the next IDLE cycle, with the rotated priority.
- Reset at any time, including mid-packet: state=IDLE, grant_q=0, rr_ptr_q=0. The partial packet is abandoned, and its recovery is upstream's responsibility.

## Timing
- Reset values: req_ready_o=0, out_valid_o=0, out_data_o=0, out_last_o=0, grant_o=0, busy_o=0.
- Arbitration latency: a request seen in IDLE at cycle n gives grant_o and busy_o high at cycle n+1. The first beat can transfer at n+1.
- Data path in LOCKED is combinational, with zero latency from req to out and from out_ready_i to req_ready_o.
- Between back-to-back packets there is exactly one IDLE bubble cycle. Peak throughput is L/(L+1) for L-beat packets.
- No combinational path from req_valid_i to grant_o.

## Structure
- Shared router_pkg holds:
  - the port index enum (HOME..WEST), NUM_PORTS, and the flit width constant 40;
  - the arb_state_t typedef {IDLE, LOCKED}.
- Sub-module rr_picker: purely combinational. Inputs are a request vector and a pointer; the output is the one-hot winner. It is reused by other round-robin points.
- The top holds the FSM, rr_ptr_q, grant_q and the AND-OR output mux.

## Test plan
- Single requester: HOME sends a 3-beat packet, data 0xA1..0xA3, with out_ready_i=1. Required: grant_o=00001 one cycle after valid, then three beats out in order, then grant_o=0 and rr_ptr=1.
- Fairness: all five requesters hold 2-beat packets continuously, with rr_ptr=0 at start. Required: grant order HOME, N, E, S, W, HOME. There is one idle cycle between packets and each port gets 2 of every 15 cycles.
- Backpressure and gaps: the locked NORTH packet drops valid for 2 cycles and out_ready_i is low for 3 cycles. Required:
  - grant stays on NORTH and no other req_ready_o rises;
  - out_valid_o tracks NORTH's valid;
  - no beat is duplicated or lost.
- Wrap-around: rr_ptr=4 and requests from EAST and WEST. Required: WEST is granted first, then rr_ptr=0, then EAST is granted next.
- Single-beat packet with a simultaneous new request: SOUTH sends a TLAST-on-first beat while HOME asserts valid in the same cycle. Required: SOUTH completes in 1 cycle, IDLE follows for 1 cycle, then HOME is granted.
- Reset mid-packet: assert rst_i during beat 2 of a 4-beat EAST packet. Required: all outputs go to 0 immediately (asynchronous), rr_ptr=0, and after release the next grant follows priority from HOME.
